// File: rtl/hhk_pkg.sv
// Shared types for the operand issuer that feeds the iterative count-up adder.
package hhk_pkg;

  localparam int unsigned HHK_WIDTH = 11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} issuer_state_t;

  typedef struct packed {
    logic [HHK_WIDTH-1:0] a;
    logic [HHK_WIDTH-1:0] b;
  } hhk_pair_t;

endpackage

// File: rtl/hhk_operand_fifo.sv
// Operand-pair FIFO: power-of-two depth, pointers wrap naturally, no pass-through when full.
module hhk_operand_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_a,
  input  logic [WIDTH-1:0]         wr_b,
  output logic [WIDTH-1:0]         rd_a,
  output logic [WIDTH-1:0]         rd_b,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_a    = mem_q[rd_ptr_q].a;
  assign rd_b    = mem_q[rd_ptr_q].b;
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = '{a: wr_a, b: wr_b};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/hhk_operand_issuer.sv
// Buffers operand pairs and serialises them through the count-up adder one at a time.
// Optional result self-check and protocol assertion: define HHK_ISSUER_CHECK_EN.
module hhk_operand_issuer
  import hhk_pkg::*;
#(
  parameter int unsigned WIDTH = HHK_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [WIDTH-1:0]       issue_a,
  output logic [WIDTH-1:0]       issue_b,
  input  logic                   done,
  input  logic [WIDTH-1:0]       res_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic [WIDTH-1:0]       out_res,
  output logic [$clog2(DEPTH):0] level
`ifdef HHK_ISSUER_CHECK_EN
 ,output logic                   chk_err
`endif
);

  issuer_state_t    state_q, state_d;
  logic             issue_valid_q, issue_valid_d;
  logic [WIDTH-1:0] issue_a_q, issue_a_d, issue_b_q, issue_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [WIDTH-1:0] head_a, head_b;
  logic             full, empty, pop;

  assign in_ready = !full;
  // The pop is the issue handshake itself; the head stays in the FIFO until then.
  assign pop = (state_q == ISSUE) && issue_valid_q && issue_ready;

  hhk_operand_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wr_a  (in_a),
    .wr_b  (in_b),
    .rd_a  (head_a),
    .rd_b  (head_b),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef HHK_ISSUER_CHECK_EN
  logic             chk_err_q, chk_err_d;
  logic [WIDTH-1:0] exp_sum;
  assign exp_sum = out_a_q + out_b_q;
  assign chk_err = chk_err_q;
`endif

  always_comb begin
    state_d       = state_q;
    issue_valid_d = issue_valid_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_res_d     = out_res_q;
`ifdef HHK_ISSUER_CHECK_EN
    chk_err_d     = chk_err_q;
`endif
    case (state_q)
      IDLE: if (!empty) begin
        state_d       = ISSUE;
        issue_valid_d = 1'b1;
        issue_a_d     = head_a;
        issue_b_d     = head_b;
      end
      ISSUE: if (issue_ready) begin
        state_d       = WAIT;
        issue_valid_d = 1'b0;
        out_a_d       = issue_a_q;
        out_b_d       = issue_b_q;
      end
      WAIT: if (done) begin
        state_d     = DRAIN;
        out_res_d   = res_in;
        out_valid_d = 1'b1;
`ifdef HHK_ISSUER_CHECK_EN
        chk_err_d   = chk_err_q || (res_in != exp_sum);
`endif
      end
      DRAIN: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      issue_valid_q <= 1'b0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_res_q     <= '0;
`ifdef HHK_ISSUER_CHECK_EN
      chk_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_res_q     <= out_res_d;
`ifdef HHK_ISSUER_CHECK_EN
      chk_err_q     <= chk_err_d;
`endif
    end
  end

`ifdef HHK_ISSUER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(issue_valid_q && (state_q == WAIT || state_q == DRAIN)));
    end
  end
`endif

  assign issue_valid = issue_valid_q;
  assign issue_a     = issue_a_q;
  assign issue_b     = issue_b_q;
  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_res     = out_res_q;

endmodule

// File: doc/hhk_operand_issuer.md
Name: hhk_operand_issuer

Overview:
Upstream stage of the iterative count-up adder (a, b, res, cnt datapath).
- Buffers operand pairs (a, b) from a producer in a small FIFO.
- Issues one pair at a time to the adder and waits for its completion pulse.
- Returns the tagged result to a consumer over valid/ready.
- Serialises all work so the adder never sees a new load while counting.

Parameters:
- WIDTH, 11, operand/result width; matches the adder's 11-bit registers.
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  FIFO can accept; equals !full.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- issue_valid  output  1  load request to adder.
- issue_ready  input  1  adder idle (its cnt==0).
- issue_a  output  WIDTH  operand a to adder.
- issue_b  output  WIDTH  operand b to adder.
- done  input  1  one-cycle pulse; adder result valid.
- res_in  input  WIDTH  adder result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_a  output  WIDTH  in-flight operand a.
- out_b  output  WIDTH  in-flight operand b.
- out_res  output  WIDTH  captured result.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, async):
  - FIFO empty, level=0, state IDLE.
  - issue_valid=0, out_valid=0.
  - issue_a/b, out_a/b, out_res = 0.
  - Any in-flight pair is discarded; a done pulse during or after reset is ignored.
- FIFO:
  - Push when in_valid && in_ready. Pop only on issue handshake.
  - When full, in_ready=0 even if a pop occurs the same cycle (no pass-through).
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop with level in 1..DEPTH-1 keeps level unchanged.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
  - IDLE: if level>0, go to ISSUE next edge; issue_a/b are loaded from the FIFO head.
  - ISSUE: issue_valid=1; issue_a/b are held stable until issue_valid && issue_ready. On the handshake: pop, copy into out_a/out_b, go to WAIT.
  - WAIT: issue_valid=0. On done: out_res <= res_in, out_valid <= 1, go to DRAIN.
  - DRAIN: out_valid, out_a/b, out_res held stable until out_ready. On out_valid && out_ready: out_valid <= 0, go to IDLE.
- Edge cases:
  - done outside WAIT is ignored.
  - out_ready outside DRAIN is ignored.
- Latency, empty FIFO in IDLE:
  - Push at edge k; issue_valid high after edge k+1.
  - Given immediate issue_ready, done, and out_ready: out_valid high after edge (done edge)+1.
  - One bubble cycle (IDLE) between consecutive pairs.
- Arithmetic: the block itself performs no arithmetic (see Optional Feature). All widths are WIDTH and no truncation occurs in the datapath.

Optional Feature:
Macro HHK_ISSUER_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0).
  - On capture in WAIT, compares res_in against (out_a + out_b) mod 2^WIDTH.
  - A mismatch sets chk_err; chk_err is sticky until reset.
  - Adds an immediate assertion that issue_valid is never high in WAIT or DRAIN.
- Undefined: port chk_err and all checking logic are absent.

Decomposition:
- Package hhk_pkg:
  - HHK_WIDTH=11 default constant.
  - issuer_state_t enum {IDLE, ISSUE, WAIT, DRAIN}.
  - Operand-pair struct {a, b}.
- Sub-module hhk_operand_fifo (parameterised WIDTH, DEPTH):
  - Storage of the pair struct, pointers, level, full/empty.
  - Same clk/rst.

Test Plan:
- Single pair: push a=300, b=200; adder model returns 500 after 200 cycles. Expect issue_a=300, issue_b=200 once; then out_valid with out_res=500, out_a=300, out_b=200.
- Fill: push 5 pairs back-to-back with issue_ready=0. Expect in_ready=0 after 4 accepted, level=4, 5th held. Then release issue_ready and expect all 5 results in push order.
- Wrap: push a=2000, b=100. With CHECK_EN, the model returns 52 ((2000+100) mod 2048) and chk_err stays 0. A model returning 53 sets chk_err=1, and it holds.
- Backpressure: out_ready=0 for 10 cycles after out_valid. out_res is stable and the next issue_valid stays 0. Asserting out_ready gives IDLE, then issue of the next pair 1 cycle later.
- Stray done: pulse done in IDLE and in DRAIN. Expect no state change and out_res unchanged.
- Reset mid-WAIT: assert rst=0 asynchronously while 2 pairs are queued. Expect immediate level=0, out_valid=0, issue_valid=0. After release, a done pulse yields no output.
